// File: rtl/morse_encoder.sv
// morse_encoder: conditions the raw active-low user button into debounced
// dot/dash symbols, measured in system-clock cycles, and packs them into a
// 2-bits-per-symbol code word (00 empty, 01 dot, 11 dash) published on commit.
module morse_encoder #(
    parameter int               CNT_W           = 26,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 26'd1000000,
    parameter logic [CNT_W-1:0] DASH_CYCLES     = 26'd12500000,
    parameter int               MAX_SYMBOLS     = 5
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     key_n,
    input  logic                     commit,
    input  logic                     clear,
    output logic [2*MAX_SYMBOLS-1:0] q,
    output logic [2:0]               symbol_count,
    output logic                     symbol_valid,
    output logic [1:0]               symbol,
    output logic                     code_valid,
    output logic [2*MAX_SYMBOLS-1:0] code_out,
    output logic                     overflow
);

    localparam int         QW      = 2 * MAX_SYMBOLS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_SYMBOLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_EMIT,
        S_WAIT_RELEASE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              key_meta;
    logic              key_sync;
    logic              db_level;
    logic [CNT_W-1:0]  db_cnt;
    logic [CNT_W-1:0]  dur;
    logic              pressed;
    logic              emit;
    logic              room;
    logic [1:0]        emit_sym;
    logic [QW-1:0]     appended;

    // The debounced level is 1 when released, so a low level means pressed.
    assign pressed = ~db_level;

    // Two-flop synchroniser for the asynchronous button; idles released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // Debouncer: the level only flips after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (key_sync != db_level) begin
            if (db_cnt == DEBOUNCE_CYCLES - CNT_W'(1)) begin
                db_level <= key_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a clear during a press abandons it until release.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (pressed) next_state = S_PRESS;
            end
            S_PRESS: begin
                if (clear)         next_state = S_WAIT_RELEASE;
                else if (!pressed) next_state = S_EMIT;
            end
            S_EMIT: begin
                next_state = S_IDLE;
            end
            S_WAIT_RELEASE: begin
                if (!pressed) next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: classify the finished press and prepare the appended word.
    always_comb begin
        emit     = (state == S_EMIT);
        emit_sym = (dur < DASH_CYCLES) ? 2'b01 : 2'b11;
        room     = (symbol_count < MAX_CNT);
        appended = {q[QW-3:0], emit_sym};
    end

    // Press-duration counter: restarts while idle, saturates at all-ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dur <= '0;
        end else if (state == S_IDLE) begin
            dur <= '0;
        end else if (state == S_PRESS && pressed && dur != '1) begin
            dur <= dur + CNT_W'(1);
        end
    end

    // Word under construction: clear beats commit, commit beats appending.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q            <= '0;
            symbol_count <= '0;
            overflow     <= 1'b0;
        end else if (clear || commit) begin
            q            <= '0;
            symbol_count <= '0;
            overflow     <= 1'b0;
        end else if (emit) begin
            if (room) begin
                q            <= appended;
                symbol_count <= symbol_count + 3'd1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Publish on commit; a symbol emitted in the same cycle is included.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            code_valid <= 1'b0;
            code_out   <= '0;
        end else begin
            code_valid <= commit & ~clear;
            if (commit && !clear) begin
                code_out <= (emit && room) ? appended : q;
            end
        end
    end

    // Symbol strobe: pulses for every classified press, even one a clear drops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            symbol_valid <= 1'b0;
            symbol       <= 2'b00;
        end else begin
            symbol_valid <= emit;
            if (emit) begin
                symbol <= emit_sym;
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: randomized presses against a symbol-list reference model;
// expected symbols and committed words are queued and checked by a monitor.
module tb_morse_encoder;

    localparam int          CNT_W = 26;
    localparam logic [25:0] DEB   = 26'd4;
    localparam logic [25:0] DASH  = 26'd10;
    localparam int          MAXS  = 5;

    logic       clock  = 1'b0;
    logic       resetn = 1'b1;
    logic       key_n  = 1'b1;
    logic       commit = 1'b0;
    logic       clear  = 1'b0;
    logic [9:0] q;
    logic [2:0] symbol_count;
    logic       symbol_valid;
    logic [1:0] symbol;
    logic       code_valid;
    logic [9:0] code_out;
    logic       overflow;

    morse_encoder #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEB),
        .DASH_CYCLES     (DASH),
        .MAX_SYMBOLS     (MAXS)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_n        (key_n),
        .commit       (commit),
        .clear        (clear),
        .q            (q),
        .symbol_count (symbol_count),
        .symbol_valid (symbol_valid),
        .symbol       (symbol),
        .code_valid   (code_valid),
        .code_out     (code_out),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sym;
        logic [9:0] word;
        logic [2:0] cnt;
        logic       ovf;
    } sym_exp_t;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    sym_exp_t   sym_q[$];
    logic [9:0] code_q[$];
    int         m_syms[$];
    bit         m_ovf = 1'b0;
    sym_exp_t   mon_e;
    logic [9:0] mon_code;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference word: symbols are base-4 digits, oldest most significant.
    function automatic logic [9:0] modelWord();
        int v = 0;
        foreach (m_syms[i]) v = v * 4 + m_syms[i];
        return 10'(v);
    endfunction

    function automatic void modelClear();
        m_syms.delete();
        m_ovf = 1'b0;
    endfunction

    // A raw hold of H cycles spends H-1 counted cycles in the pressed state.
    task automatic modelPress(input int hold, input bit with_commit);
        sym_exp_t   e;
        logic [1:0] s;
        s = ((hold - 1) >= int'(DASH)) ? 2'b11 : 2'b01;
        if (m_syms.size() < MAXS) m_syms.push_back(int'(s));
        else m_ovf = 1'b1;
        if (with_commit) begin
            code_q.push_back(modelWord());
            modelClear();
        end
        e.sym  = s;
        e.word = modelWord();
        e.cnt  = 3'(m_syms.size());
        e.ovf  = m_ovf;
        sym_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int hold, input int gap);
        modelPress(hold, 1'b0);
        key_n = 1'b0;
        repeat (hold) tick();
        key_n = 1'b1;
        repeat (gap) tick();
    endtask

    // Release, then raise commit exactly in the cycle the symbol is emitted.
    task automatic pressWithCommit(input int hold);
        modelPress(hold, 1'b1);
        key_n = 1'b0;
        repeat (hold) tick();
        key_n = 1'b1;
        repeat (7) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (10) tick();
    endtask

    task automatic doCommit();
        code_q.push_back(modelWord());
        modelClear();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (3) tick();
    endtask

    task automatic checkWord(input string tag);
        checkOutput({tag, ".q"}, 32'(q), 32'(modelWord()));
        checkOutput({tag, ".count"}, 32'(symbol_count), 32'(m_syms.size()));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".q"}, 32'(q), 32'd0);
        checkOutput({tag, ".count"}, 32'(symbol_count), 32'd0);
        checkOutput({tag, ".symbol_valid"}, 32'(symbol_valid), 32'd0);
        checkOutput({tag, ".symbol"}, 32'(symbol), 32'd0);
        checkOutput({tag, ".code_valid"}, 32'(code_valid), 32'd0);
        checkOutput({tag, ".code_out"}, 32'(code_out), 32'd0);
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a symbol or a word.
    always @(negedge clock) begin
        if (resetn) begin
            if (symbol_valid) begin
                if (sym_q.size() == 0) begin
                    checkOutput("unexpected_symbol_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sym_q.pop_front();
                    checkOutput("symbol", 32'(symbol), 32'(mon_e.sym));
                    checkOutput("symbol.q", 32'(q), 32'(mon_e.word));
                    checkOutput("symbol.count", 32'(symbol_count), 32'(mon_e.cnt));
                    checkOutput("symbol.overflow", 32'(overflow), 32'(mon_e.ovf));
                end
            end
            if (code_valid) begin
                if (code_q.size() == 0) begin
                    checkOutput("unexpected_code_valid", 32'd1, 32'd0);
                end else begin
                    mon_code = code_q.pop_front();
                    checkOutput("code_out", 32'(code_out), 32'(mon_code));
                    checkOutput("commit.q", 32'(q), 32'd0);
                    checkOutput("commit.count", 32'(symbol_count), 32'd0);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hold;
        int gap;

        #1 resetn = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        resetn = 1'b1;
        repeat (2) tick();

        $display("[TB] dot and dash");
        applyStimulus(8, 12);
        checkWord("dot");
        applyStimulus(20, 12);
        applyStimulus(8, 12);
        checkWord("dash_dot");
        doCommit();

        $display("[TB] glitch rejection");
        applyStimulus(6, 12);
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            repeat (3) tick();
            key_n = 1'b1;
            repeat (3) tick();
        end
        repeat (12) tick();
        checkWord("glitch");
        doCommit();

        $display("[TB] overflow");
        for (int i = 0; i < 6; i++) applyStimulus(8, 12);
        checkWord("overflow");
        doCommit();
        checkWord("after_commit");

        $display("[TB] dash threshold and empty commit");
        applyStimulus(10, 12);
        applyStimulus(11, 12);
        checkWord("threshold");
        doCommit();
        doCommit();

        $display("[TB] commit coinciding with emit");
        applyStimulus(8, 12);
        pressWithCommit(20);
        checkWord("coincide");

        $display("[TB] randomized presses");
        for (int i = 0; i < 40; i++) begin
            hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 9)) : int'($urandom_range(12, 24));
            gap  = int'($urandom_range(10, 16));
            applyStimulus(hold, gap);
            if ($urandom_range(0, 3) == 0) begin
                key_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                key_n = 1'b1;
                repeat (10) tick();
            end
            if ($urandom_range(0, 5) == 0) doCommit();
        end
        checkWord("random");
        doCommit();

        $display("[TB] clear mid-press");
        applyStimulus(6, 12);
        key_n = 1'b0;
        repeat (10) tick();
        clear = 1'b1;
        modelClear();
        tick();
        clear = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        repeat (12) tick();
        checkWord("clear");

        $display("[TB] reset mid-press");
        applyStimulus(6, 12);
        doCommit();
        applyStimulus(20, 12);
        key_n = 1'b0;
        repeat (9) tick();
        #2 resetn = 1'b0;
        #1 checkAllZero("async_reset");
        modelClear();
        @(posedge clock);
        #1 resetn = 1'b1;
        modelPress(8, 1'b0);
        repeat (8) tick();
        key_n = 1'b1;
        repeat (12) tick();
        checkWord("post_reset");
        doCommit();
        repeat (5) tick();

        checkOutput("pending_symbols", 32'(sym_q.size()), 32'd0);
        checkOutput("pending_codes", 32'(code_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Upstream conditioning stage for the player input datapath: turns the raw active-low user button into debounced dot/dash symbols.
- Packs the symbols into the 10-bit, 2-bits-per-symbol code word used by the player, RAM and translator stages (00 empty, 01 dot, 11 dash).
- Emits the completed code word on a commit strobe. Runs on the fast system clock, so press timing is measured in cycles rather than 2 Hz ticks.

Parameters:
- CNT_W, 26, width of the debounce and press-duration counters.
- DEBOUNCE_CYCLES, 26'd1000000, consecutive stable cycles required before the debounced level changes (20 ms at 50 MHz).
- DASH_CYCLES, 26'd12500000, press duration at or above which a symbol is a dash (250 ms).
- MAX_SYMBOLS, 5, symbols per code word; q is 2*MAX_SYMBOLS bits wide.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- key_n  in  1  raw button, 0 = pressed, asynchronous to clock.
- commit  in  1  one-cycle pulse; publish the current word and start a new one.
- clear  in  1  one-cycle pulse; discard the current word.
- q  out  10  word under construction; newest symbol in q[1:0].
- symbol_count  out  3  number of symbols in q, 0..5.
- symbol_valid  out  1  one-cycle pulse when a symbol is classified.
- symbol  out  2  last classified symbol, 01 or 11.
- code_valid  out  1  one-cycle pulse carrying the committed word.
- code_out  out  10  committed word; held until the next commit.
- overflow  out  1  sticky; a symbol was dropped because the word was full.

Behaviour:
- Reset, asynchronous: all outputs 0, both counters 0, synchroniser flops 1 (released), debounced level released, FSM in S_IDLE.
- Synchroniser: key_n passes through 2 flops.
- Debouncer:
  - The counter increments while the synchronised level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Latency from a clean raw edge to the debounced edge: 2 + DEBOUNCE_CYCLES cycles.
- FSM states: S_IDLE, S_PRESS, S_EMIT, S_WAIT_RELEASE.
  - S_IDLE: on debounced press, go to S_PRESS with dur = 0.
  - S_PRESS: dur increments each cycle while pressed and saturates at all-ones. On debounced release, go to S_EMIT.
  - S_EMIT (one cycle):
    - symbol = 01 if dur < DASH_CYCLES, else 11; symbol_valid = 1; go to S_IDLE.
    - If symbol_count < MAX_SYMBOLS: q <= {q[7:0], symbol} and symbol_count increments.
    - Otherwise q is unchanged and overflow <= 1.
  - S_WAIT_RELEASE: entered on clear while in S_PRESS. Ignores the press in progress, emits no symbol, and returns to S_IDLE on debounced release.
- Commit, in any state:
  - Next cycle: code_valid = 1 for one cycle, code_out = q.
  - Same edge: q, symbol_count and overflow clear.
  - If commit coincides with S_EMIT, the emitted symbol is included in code_out (append first, then publish).
  - A commit with symbol_count = 0 still pulses code_valid with code_out = 0.
- Clear:
  - Synchronously zeroes q, symbol_count and overflow.
  - Priority: clear > commit > emit. When clear and commit coincide, no code_valid is produced.
  - clear during S_EMIT drops the symbol, but symbol_valid still pulses.
  - clear during S_PRESS goes to S_WAIT_RELEASE.
- The FSM only acts on debounced edges, so glitches shorter than DEBOUNCE_CYCLES have no effect.
- Reset asserted mid-press returns everything to reset values immediately. After release of reset, a still-held key is seen as a fresh press once it has been debounced.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, DASH_CYCLES=10.
- Dot: hold key_n=0 for 8 cycles, then release -> symbol_valid pulses once, symbol=01, q=10'b00_0000_0001, symbol_count=1.
- Dash: hold 20 cycles -> symbol=11. Then a dot press -> q=10'b00_0000_1101, symbol_count=2.
- Glitch rejection: key_n low for 3 cycles, repeated 5 times with 3-cycle highs between -> no symbol_valid, q unchanged.
- Overflow: 6 dot presses -> q=10'b01_0101_0101, symbol_count=5, overflow=1 after the 6th. Then commit -> code_valid one cycle with code_out=10'b0101010101, and q=0, count=0, overflow=0 after the commit edge.
- Coincidence: commit asserted in the S_EMIT cycle of a dash following one dot -> code_out=10'b00_0000_0111, q=0.
- Clear mid-press then async reset: assert clear while a press is held, then release the key -> no symbol_valid, q=0. Then assert resetn=0 mid-press -> all outputs 0 within the same cycle.
